// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver and Set-2 scan-code parser.
// Ports: clk; resetN (async, active-high); ps2_clk/ps2_data raw pins;
//   keyCode {extended, scan byte}; make/brakee key event pulses;
//   byteValid good-byte pulse; frameErr discarded-frame pulse.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brakee,
    output logic       byteValid,
    output logic       frameErr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        P_IDLE,
        P_EXT,
        P_BRK,
        P_EXT_BRK
    } pstate_t;

    // Two synchroniser stages plus one history stage on ps2_clk.
    // Reset to 1 (idle line level) so no false edge follows reset.
    logic [2:0] clk_sync;
    logic [1:0] dat_sync;
    logic       fall;
    logic       bit_in;

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = dat_sync[1];

    // Frame receiver
    logic          busy;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic [7:0]    rx_byte;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            busy      <= 1'b0;
            bit_cnt   <= 4'd0;
            shreg     <= 9'd0;
            rx_byte   <= 8'd0;
            to_cnt    <= '0;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
            if (!busy) begin
                to_cnt <= '0;
                if (fall && !bit_in) begin
                    busy    <= 1'b1;
                    bit_cnt <= 4'd1;
                end
            end else if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    busy    <= 1'b0;
                    bit_cnt <= 4'd0;
                    // data bits plus parity must hold an odd count of ones
                    if (bit_in && (^shreg)) begin
                        byteValid <= 1'b1;
                        rx_byte   <= shreg[7:0];
                    end else begin
                        frameErr <= 1'b1;
                    end
                end else begin
                    // LSB arrives first; after 9 shifts data sits in [7:0]
                    shreg   <= {bit_in, shreg[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                busy     <= 1'b0;
                bit_cnt  <= 4'd0;
                to_cnt   <= '0;
                frameErr <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Scan-code parser
    pstate_t pstate;
    logic    in_ext;
    logic    in_brk;
    logic    noise;

    assign in_ext = (pstate == P_EXT) || (pstate == P_EXT_BRK);
    assign in_brk = (pstate == P_BRK) || (pstate == P_EXT_BRK);

    // Keyboard status/ack bytes that carry no key event
    always_comb begin
        noise = 1'b0;
        case (rx_byte)
            8'hAA, 8'hFA, 8'hFE, 8'hEE,
            8'h00, 8'hFF, 8'hE1: noise = 1'b1;
            default:             noise = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            pstate  <= P_IDLE;
            keyCode <= 9'h000;
            make    <= 1'b0;
            brakee  <= 1'b0;
        end else begin
            make   <= 1'b0;
            brakee <= 1'b0;
            if (frameErr) begin
                pstate <= P_IDLE;
            end else if (byteValid) begin
                if (rx_byte == 8'hE0) begin
                    pstate <= P_EXT;
                end else if (rx_byte == 8'hF0) begin
                    pstate <= in_ext ? P_EXT_BRK : P_BRK;
                end else if (pstate == P_IDLE && noise) begin
                    pstate <= P_IDLE;
                end else begin
                    keyCode <= {in_ext, rx_byte};
                    make    <= ~in_brk;
                    brakee  <= in_brk;
                    pstate  <= P_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx: table of frames with expected
// pulse counts and keyCode, plus timeout and mid-frame reset sequences.
module tb_ps2_scancode_rx;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] keyCode;
    logic       make;
    logic       brakee;
    logic       byteValid;
    logic       frameErr;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int bv_n = 0, mk_n = 0, br_n = 0, er_n = 0, both_n = 0;
    int bv_cyc = 0, ev_cyc = 0;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .resetN(resetN),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .keyCode(keyCode),
        .make(make),
        .brakee(brakee),
        .byteValid(byteValid),
        .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!resetN) begin
            if (byteValid) begin
                bv_n   <= bv_n + 1;
                bv_cyc <= cyc;
            end
            if (make) begin
                mk_n   <= mk_n + 1;
                ev_cyc <= cyc;
            end
            if (brakee) begin
                br_n   <= br_n + 1;
                ev_cyc <= cyc;
            end
            if (frameErr) er_n <= er_n + 1;
            if (make && brakee) both_n <= both_n + 1;
        end
    end

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        int         bv;
        int         mk;
        int         br;
        int         er;
        logic [8:0] key;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic clr();
        @(posedge clk);
        bv_n = 0; mk_n = 0; br_n = 0; er_n = 0;
    endtask

    task automatic send_bit(input logic d);
        ps2_data = d;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    // Sends the first nbits of a frame (11 = whole frame).
    task automatic send_frame(input logic [7:0] b, input bit bp,
                              input bit bs, input int nbits);
        logic [10:0] f;
        f = {~bs, (~^b) ^ bp, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        v[0]  = '{8'h29, 0, 0, 1, 1, 0, 0, 9'h029};
        v[1]  = '{8'hF0, 0, 0, 1, 0, 0, 0, 9'h029};
        v[2]  = '{8'h29, 0, 0, 1, 0, 1, 0, 9'h029};
        v[3]  = '{8'hE0, 0, 0, 1, 0, 0, 0, 9'h029};
        v[4]  = '{8'h75, 0, 0, 1, 1, 0, 0, 9'h175};
        v[5]  = '{8'hE0, 0, 0, 1, 0, 0, 0, 9'h175};
        v[6]  = '{8'hF0, 0, 0, 1, 0, 0, 0, 9'h175};
        v[7]  = '{8'h75, 0, 0, 1, 0, 1, 0, 9'h175};
        v[8]  = '{8'h29, 1, 0, 0, 0, 0, 1, 9'h175};
        v[9]  = '{8'h1C, 0, 0, 1, 1, 0, 0, 9'h01C};
        v[10] = '{8'hAA, 0, 0, 1, 0, 0, 0, 9'h01C};
        v[11] = '{8'h12, 0, 1, 0, 0, 0, 1, 9'h01C};
        v[12] = '{8'hF0, 0, 0, 1, 0, 0, 0, 9'h01C};
        v[13] = '{8'hE1, 0, 0, 1, 0, 1, 0, 9'h0E1};
        v[14] = '{8'hF0, 1, 0, 0, 0, 0, 1, 9'h0E1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_key", int'(keyCode), 0);
        chk("rst_make", int'(make), 0);
        chk("rst_brk", int'(brakee), 0);
        chk("rst_bv_err", int'(byteValid | frameErr), 0);
        @(posedge clk);
        resetN = 1'b0;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            clr();
            send_frame(v[i].b, v[i].bad_par, v[i].bad_stop, 11);
            chk($sformatf("v%0d_bv", i), bv_n, v[i].bv);
            chk($sformatf("v%0d_make", i), mk_n, v[i].mk);
            chk($sformatf("v%0d_brk", i), br_n, v[i].br);
            chk($sformatf("v%0d_err", i), er_n, v[i].er);
            chk($sformatf("v%0d_key", i), int'(keyCode), int'(v[i].key));
        end

        // A frame error clears a pending F0 prefix; E0 resyncs from break
        clr();
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'h6B, 0, 0, 11);
        chk("resync_make", mk_n, 1);
        chk("resync_brk", br_n, 0);
        chk("resync_key", int'(keyCode), 9'h16B);

        // Timeout mid-frame after an F0 prefix
        clr();
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h29, 0, 0, 5);
        repeat (TO + 50) @(posedge clk);
        chk("to_err", er_n, 1);
        chk("to_bv", bv_n, 1);
        clr();
        send_frame(8'h29, 0, 0, 11);
        chk("to_make", mk_n, 1);
        chk("to_brk", br_n, 0);
        chk("to_key", int'(keyCode), 9'h029);

        // Reset in the middle of a frame
        clr();
        send_frame(8'h1C, 0, 0, 4);
        resetN = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mr_key", int'(keyCode), 0);
        chk("mr_out", int'({make, brakee, byteValid, frameErr}), 0);
        @(posedge clk);
        resetN = 1'b0;
        repeat (5) @(posedge clk);
        clr();
        send_frame(8'h29, 0, 0, 11);
        chk("mr_make", mk_n, 1);
        chk("mr_bv", bv_n, 1);
        chk("mr_err", er_n, 0);
        chk("mr_key", int'(keyCode), 9'h029);
        chk("lat_bv_to_make", ev_cyc - bv_cyc, 1);

        chk("never_both", both_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
